// File: rtl/edge_frame_sequencer.sv
// edge_frame_sequencer
// Frame-level controller for the Sobel edge-detection core. It advances the
// core one raster position per step and feeds it pixels from a source frame
// memory. Each valid result is written to a destination frame memory.
// The default build writes min(magnitude, 255) to the destination frame.
// Define EDGE_THRESHOLD_EN to write binary pixels instead:
// 0xFF when magnitude >= threshold, 0x00 otherwise.
module edge_frame_sequencer #(
   parameter int ROW_NUM = 480,
   parameter int COL_NUM = 640,
   parameter int ADDR_W  = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   input  logic [7:0]        threshold,
   output logic              busy,
   output logic              done,
   output logic [15:0]       frame_count,
   output logic              core_en,
   output logic              core_waitrequest,
   output logic [7:0]        core_pixel,
   input  logic [10:0]       core_next_x,
   input  logic [10:0]       core_next_y,
   input  logic              core_read_valid,
   input  logic [10:0]       core_out_x,
   input  logic [10:0]       core_out_y,
   input  logic [10:0]       core_pixel_out,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_ack,
   input  logic [7:0]        rd_data,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   input  logic              wr_ack
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_STEP  = 3'd2;
   localparam logic [2:0] S_EVAL  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_FIN   = 3'd5;

   localparam logic [10:0]       COL_LIM    = 11'(COL_NUM);
   localparam logic [10:0]       ROW_LIM    = 11'(ROW_NUM);
   localparam logic [10:0]       LAST_X     = 11'(COL_NUM - 1);
   localparam logic [10:0]       LAST_Y     = 11'(ROW_NUM - 1);
   localparam logic [ADDR_W-1:0] COL_STRIDE = ADDR_W'(COL_NUM);

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [ADDR_W-1:0] src_lat;
   logic [ADDR_W-1:0] dst_lat;
   logic              next_in_range;
   logic              last_pos;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [7:0]        result_pixel;

   // The core asks for padding positions past the right and bottom edges; those are fed as 0.
   assign next_in_range = (core_next_x < COL_LIM) && (core_next_y < ROW_LIM);

   // The step taken while the core holds the last result is the one that returns it to idle.
   assign last_pos = (core_out_x == LAST_X) && (core_out_y == LAST_Y);

   // Raster addresses wrap modulo 2^ADDR_W.
   assign src_addr = src_lat + ADDR_W'(core_next_y) * COL_STRIDE + ADDR_W'(core_next_x);
   assign dst_addr = dst_lat + ADDR_W'(core_out_y) * COL_STRIDE + ADDR_W'(core_out_x);

`ifdef EDGE_THRESHOLD_EN
   // Binary edge map.
   assign result_pixel = (core_pixel_out >= {3'b000, threshold}) ? 8'hFF : 8'h00;
`else
   // Saturate the 0..2040 magnitude into a byte. The threshold input has no effect in this build.
   logic unused_threshold;
   assign unused_threshold = ^threshold;
   assign result_pixel = (core_pixel_out > 11'd255) ? 8'hFF : core_pixel_out[7:0];
`endif

   // Outputs are decoded from the state. Address and data are forced to 0 when no request is active.
   // They stay stable while a request is held because the core does not move until STEP.
   assign rd_req           = (state == S_FETCH) && next_in_range;
   assign rd_addr          = rd_req ? src_addr : '0;
   assign wr_req           = (state == S_WRITE);
   assign wr_addr          = wr_req ? dst_addr : '0;
   assign wr_data          = wr_req ? result_pixel : '0;
   assign core_waitrequest = (state != S_STEP);
   assign busy             = (state != S_IDLE);
   assign core_en          = (state != S_IDLE);
   assign done             = (state == S_FIN);

   // Next-state logic for the per-position fetch/step/evaluate/write loop.
   always_comb begin
      // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_FETCH;
         S_FETCH: if (!next_in_range || rd_ack) state_nxt = S_STEP;
         S_STEP:  state_nxt = last_pos ? S_FIN : S_EVAL;
         S_EVAL:  state_nxt = core_read_valid ? S_WRITE : S_FETCH;
         S_WRITE: if (wr_ack) state_nxt = S_FETCH;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register; reset aborts any frame in progress immediately.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Frame base addresses are captured only when a start is accepted from IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_lat <= '0;
         dst_lat <= '0;
      end else if ((state == S_IDLE) && start) begin
         src_lat <= src_base;
         dst_lat <= dst_base;
      end
   end

   // Pixel presented to the core: the read data, or 0 for padding positions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_pixel <= '0;
      end else if (state == S_FETCH) begin
         if (!next_in_range) begin
            core_pixel <= '0;
         end else if (rd_ack) begin
            core_pixel <= rd_data;
         end
      end
   end

   // Completed-frame counter, wrapping at 2^16.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_count <= '0;
      end else if (state == S_FIN) begin
         frame_count <= frame_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_edge_frame_sequencer.sv
// tb_edge_frame_sequencer
// Drives edge_frame_sequencer on a 4x4 image. The bench provides three models:
//  - a behavioural Sobel core;
//  - source and destination memories with random or fixed acknowledge delays;
//  - a reference computed directly from the source image with zero padding.
`timescale 1ns/1ps
module tb_edge_frame_sequencer;

   localparam int R          = 4;
   localparam int C          = 4;
   localparam int NPIX       = R * C;
   localparam int NPOS       = (R + 1) * (C + 1);
   localparam int AW         = 19;
   localparam int MAX_CYCLES = 3000;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] src_base = '0;
   logic [AW-1:0] dst_base = '0;
   logic [7:0]    threshold = 8'h80;
   logic          busy, done, core_en, core_waitrequest;
   logic [15:0]   frame_count;
   logic [7:0]    core_pixel;
   logic [10:0]   core_next_x, core_next_y, core_out_x, core_out_y, core_pixel_out;
   logic          core_read_valid;
   logic          rd_req, wr_req;
   logic [AW-1:0] rd_addr, wr_addr;
   logic          rd_ack = 1'b0;
   logic          wr_ack = 1'b0;
   logic [7:0]    rd_data = 8'h00;
   logic [7:0]    wr_data;

   always #5 clk = ~clk;

   edge_frame_sequencer #(.ROW_NUM(R), .COL_NUM(C), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
      .threshold(threshold), .busy(busy), .done(done), .frame_count(frame_count),
      .core_en(core_en), .core_waitrequest(core_waitrequest), .core_pixel(core_pixel),
      .core_next_x(core_next_x), .core_next_y(core_next_y), .core_read_valid(core_read_valid),
      .core_out_x(core_out_x), .core_out_y(core_out_y), .core_pixel_out(core_pixel_out),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   // ---------------- shared scenario state ----------------
   logic [7:0]    src_img [0:NPIX-1];
   logic [7:0]    exp_img [0:NPIX-1];
   logic [7:0]    wr_img  [0:NPIX-1];
   bit            wr_seen [0:NPIX-1];
   logic [AW-1:0] cur_src, cur_dst;
   int            frame_wr_base = 0;
   int            ack_mode = -1;   // -1: random 0..3 cycles, otherwise fixed delay
   int            total_reads = 0, total_writes = 0, total_steps = 0, total_done = 0;

   // ---------------- Sobel arithmetic ----------------
   function automatic int sobel(input int p [0:2][0:2]);
      int gx, gy;
      gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
      gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
      return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
   endfunction

   // Reference magnitude straight from the source image, zero outside the frame.
   function automatic int ref_mag(input int x, input int y);
      int p [0:2][0:2];
      int xx, yy;
      for (int dy = 0; dy < 3; dy++)
         for (int dx = 0; dx < 3; dx++) begin
            xx = x + dx - 1;
            yy = y + dy - 1;
            p[dy][dx] = 0;
            if (xx >= 0 && xx < C && yy >= 0 && yy < R) p[dy][dx] = int'(src_img[yy * C + xx]);
         end
      return sobel(p);
   endfunction

   function automatic logic [7:0] expect_pixel(input int mag);
`ifdef EDGE_THRESHOLD_EN
      return (mag >= int'(threshold)) ? 8'hFF : 8'h00;
`else
      return (mag > 255) ? 8'hFF : 8'(mag);
`endif
   endfunction

   // ---------------- behavioural core ----------------
   // Consumes one pixel per step over a (R+1)x(C+1) raster. Output (x-1,y-1) becomes valid
   // after pixel (x,y) arrives. One extra closing step returns the core to idle.
   int         k = 0;
   int         mx, my;
   logic [7:0] rx [0:R][0:C];
   logic       m_valid = 1'b0;
   logic [10:0] m_out_x = '0, m_out_y = '0, m_mag = '0;

   function automatic int core_mag(input int ox, input int oy);
      int p [0:2][0:2];
      int xx, yy;
      for (int dy = 0; dy < 3; dy++)
         for (int dx = 0; dx < 3; dx++) begin
            xx = ox + dx - 1;
            yy = oy + dy - 1;
            p[dy][dx] = 0;
            if (xx >= 0 && yy >= 0) p[dy][dx] = int'(rx[yy][xx]);
         end
      return sobel(p);
   endfunction

   assign core_next_x     = 11'(k % (C + 1));
   assign core_next_y     = 11'(k / (C + 1));
   assign core_read_valid = m_valid;
   assign core_out_x      = m_out_x;
   assign core_out_y      = m_out_y;
   assign core_pixel_out  = m_mag;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         k <= 0; m_valid <= 1'b0; m_out_x <= '0; m_out_y <= '0; m_mag <= '0;
      end else if (core_en && !core_waitrequest) begin
         total_steps <= total_steps + 1;
         if (k >= NPOS) begin
            k <= 0; m_valid <= 1'b0; m_out_x <= '0; m_out_y <= '0;
         end else begin
            mx = k % (C + 1);
            my = k / (C + 1);
            rx[my][mx] = core_pixel;
            if (mx >= 1 && my >= 1) begin
               m_valid <= 1'b1;
               m_out_x <= 11'(mx - 1);
               m_out_y <= 11'(my - 1);
               m_mag   <= 11'(core_mag(mx - 1, my - 1));
            end else begin
               m_valid <= 1'b0;
            end
            k <= k + 1;
         end
      end
   end

   // ---------------- memories and write scoreboard ----------------
   int            rd_wait = -1, wr_wait = -1, mon_idx;
   logic [AW-1:0] rd_hold, wr_hold_addr, mon_off, exp_addr;
   logic [7:0]    wr_hold_data;

   function automatic int pick_delay();
      return (ack_mode < 0) ? int'($urandom_range(3, 0)) : ack_mode;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         rd_ack = 1'b0; wr_ack = 1'b0; rd_wait = -1; wr_wait = -1;
      end else begin
         if (done === 1'b1) total_done++;
         if (rd_req || wr_req) check("req_overlap", {31'b0, rd_req & wr_req}, 32'd0);
         // source memory
         if (rd_ack) begin
            rd_ack = 1'b0; rd_wait = -1;
         end else if (rd_req) begin
            if (rd_wait < 0) begin rd_wait = pick_delay(); rd_hold = rd_addr; end
            if (rd_wait == 0) begin
               exp_addr = cur_src + AW'(core_next_y) * AW'(C) + AW'(core_next_x);
               check("rd_addr", rd_addr, exp_addr);
               check("rd_addr_stable", rd_addr, rd_hold);
               mon_off = rd_addr - cur_src;
               rd_data = (int'(mon_off) < NPIX) ? src_img[int'(mon_off)] : 8'h00;
               rd_ack = 1'b1;
               total_reads++;
            end else rd_wait--;
         end else rd_wait = -1;
         // destination memory
         if (wr_ack) begin
            wr_ack = 1'b0; wr_wait = -1;
         end else if (wr_req) begin
            if (wr_wait < 0) begin wr_wait = pick_delay(); wr_hold_addr = wr_addr; wr_hold_data = wr_data; end
            if (wr_wait == 0) begin
               mon_off = wr_addr - cur_dst;
               mon_idx = total_writes - frame_wr_base;
               check("wr_raster_order", mon_off, mon_idx);
               check("wr_hold_stable", {wr_addr, wr_data}, {wr_hold_addr, wr_hold_data});
               if (mon_idx < NPIX) check("wr_data", wr_data, exp_img[mon_idx]);
               else check("wr_count_excess", mon_idx, NPIX - 1);
               if (int'(mon_off) < NPIX) begin
                  wr_img[int'(mon_off)] = wr_data;
                  wr_seen[int'(mon_off)] = 1'b1;
               end
               wr_ack = 1'b1;
               total_writes++;
            end else wr_wait--;
         end else wr_wait = -1;
      end
   end

   // ---------------- directed sequence ----------------
   task automatic check_reset_outputs();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_core_en", core_en, 0);
      check("rst_core_waitrequest", core_waitrequest, 1);
      check("rst_core_pixel", core_pixel, 0);
      check("rst_rd_req", rd_req, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_wr_req", wr_req, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
   endtask

   // Called just after a falling edge: prepares the expected image and pulses start.
   task automatic start_frame();
      cur_src = AW'($urandom);
      cur_dst = AW'($urandom);
      for (int i = 0; i < NPIX; i++) begin
         exp_img[i] = expect_pixel(ref_mag(i % C, i / C));
         wr_seen[i] = 1'b0;
      end
      frame_wr_base = total_writes;
      src_base = cur_src;
      dst_base = cur_dst;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      src_base = AW'($urandom);   // the latched bases must be the ones used
      dst_base = AW'($urandom);
      check("busy_after_start", busy, 1);
   endtask

   task automatic run_frame(input int fc_exp, input bit poke_mid, input bit poke_fin);
      int r0, s0, d0, covered;
      bit seen;
      r0 = total_reads; s0 = total_steps; d0 = total_done;
      start_frame();
      seen = 1'b0;
      for (int i = 0; i < MAX_CYCLES && !seen; i++) begin
         start = poke_mid && (i == 40);
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      check("done_seen", seen, 1);
      start = poke_fin;           // lands in the FIN cycle
      @(negedge clk);
      start = 1'b0;
      check("idle_after_fin", busy, 0);
      check("done_one_cycle", done, 0);
      check("frame_count", frame_count, fc_exp);
      check("reads_per_frame", total_reads - r0, NPIX);
      check("writes_per_frame", total_writes - frame_wr_base, NPIX);
      check("steps_per_frame", total_steps - s0, NPOS + 1);
      check("done_pulses", total_done - d0, 1);
      covered = 0;
      for (int i = 0; i < NPIX; i++) covered += int'(wr_seen[i]);
      check("image_coverage", covered, NPIX);
   endtask

   logic [7:0] img_a [0:NPIX-1];

   initial begin
      int diffs, d_before;
      bit seen;

      // Asynchronous reset before the first rising edge.
      #2 rst = 1'b1;
      #1 check_reset_outputs();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Flat 0x40 image, random acknowledge delays.
      for (int i = 0; i < NPIX; i++) src_img[i] = 8'h40;
      run_frame(1, 1'b0, 1'b0);
      check("flat_out_1_1", wr_img[1 * C + 1], 8'h00);
      check("flat_out_2_2", wr_img[2 * C + 2], 8'h00);
      check("flat_out_0_0", wr_img[0], 8'hFF);

      // Columns 0-1 dark, columns 2-3 bright.
      for (int i = 0; i < NPIX; i++) src_img[i] = ((i % C) >= 2) ? 8'hFF : 8'h00;
      run_frame(2, 1'b0, 1'b0);
      check("cols_out_x1_y1", wr_img[1 * C + 1], 8'hFF);
      check("cols_out_x1_y0", wr_img[1], 8'hFF);

      // Same random image with zero-wait and three-cycle acknowledges.
      for (int i = 0; i < NPIX; i++) src_img[i] = 8'($urandom_range(255, 0));
      ack_mode = 0;
      run_frame(3, 1'b0, 1'b0);
      for (int i = 0; i < NPIX; i++) img_a[i] = wr_img[i];
      ack_mode = 3;
      run_frame(4, 1'b0, 1'b0);
      diffs = 0;
      for (int i = 0; i < NPIX; i++) if (wr_img[i] !== img_a[i]) diffs++;
      check("ack3_image_match", diffs, 0);
      ack_mode = -1;

      // Start mid-frame and in the FIN cycle is ignored; then a back-to-back frame.
      d_before = total_done;
      for (int i = 0; i < NPIX; i++) src_img[i] = 8'($urandom_range(255, 0));
      run_frame(5, 1'b1, 1'b1);
      for (int i = 0; i < NPIX; i++) src_img[i] = 8'($urandom_range(255, 0));
      run_frame(6, 1'b0, 1'b0);
      check("two_done_pulses", total_done - d_before, 2);

      // Reset partway through a frame, then a full frame after it.
      for (int i = 0; i < NPIX; i++) src_img[i] = 8'($urandom_range(255, 0));
      start_frame();
      seen = 1'b0;
      for (int i = 0; i < MAX_CYCLES && !seen; i++) begin
         @(negedge clk);
         if (total_writes - frame_wr_base >= 7) seen = 1'b1;
      end
      check("reached_write_7", seen, 1);
      #2 rst = 1'b1;
      #1 check_reset_outputs();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NPIX; i++) src_img[i] = 8'($urandom_range(255, 0));
      run_frame(1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
